// File: rtl/barrier_scroller.sv
// Scrolling barrier field with internal pipe spawner, bird collision detection and score counter.
// Optional macro BARRIER_LFSR_EN replaces gap_pos with an internal 8-bit LFSR as the gap source.
module barrier_scroller #(
    parameter int ROWS       = 8,
    parameter int NUM_COLS   = 16,
    parameter int SPACING    = 4,
    parameter int PIPE_WIDTH = 2,
    parameter int GAP_SIZE   = 3,
    parameter int BIRD_COL   = 3,
    parameter int SCORE_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pause,
    input  logic                     enable2,
    input  logic                     run,
    input  logic [$clog2(ROWS)-1:0]  gap_pos,
    input  logic [ROWS-1:0]          bird,
    output logic [NUM_COLS*ROWS-1:0] field,
    output logic                     collision,
    output logic [SCORE_W-1:0]       score,
    output logic                     pipe_passed
);

    localparam int GW      = $clog2(ROWS);
    localparam int CW      = $clog2(((SPACING > PIPE_WIDTH) ? SPACING : PIPE_WIDTH) + 1);
    localparam int MAX_GAP = ROWS - GAP_SIZE;

    typedef enum logic {S_SPACE, S_PIPE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [GW-1:0]   gap, gap_next, gap_src;
    logic [NUM_COLS-1:0] tags;
    logic [ROWS-1:0] new_col, pipe_mask;
    logic            new_tag;
    logic            step, hit, score_event;

    assign step = enable2 & ~pause;

`ifdef BARRIER_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 8'hA5;
        else if (step)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign gap_src = GW'(int'(lfsr) % (MAX_GAP + 1));
`else
    assign gap_src = (int'(gap_pos) > MAX_GAP) ? GW'(MAX_GAP) : gap_pos;
`endif

    always_comb begin
        for (int r = 0; r < ROWS; r++)
            pipe_mask[r] = !((r >= int'(gap)) && (r < int'(gap) + GAP_SIZE));
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        gap_next   = gap;
        new_col    = '0;
        new_tag    = 1'b0;
        if (!run) begin
            state_next = S_SPACE;
            cnt_next   = '0;
        end else begin
            case (state)
                S_SPACE: begin
                    if (cnt == CW'(SPACING - 1)) begin
                        state_next = S_PIPE;
                        cnt_next   = '0;
                        gap_next   = gap_src;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                S_PIPE: begin
                    new_col = pipe_mask;
                    if (cnt == CW'(PIPE_WIDTH - 1)) begin
                        new_tag    = 1'b1;
                        state_next = S_SPACE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: state_next = S_SPACE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_SPACE;
            cnt   <= '0;
            gap   <= '0;
            field <= '0;
            tags  <= '0;
        end else if (step) begin
            state <= state_next;
            cnt   <= cnt_next;
            gap   <= gap_next;
            field <= {new_col, field[NUM_COLS*ROWS-1:ROWS]};
            tags  <= {new_tag, tags[NUM_COLS-1:1]};
        end
    end

    // The trailing (tagged) column of a pipe leaving the bird column counts as a pass.
    assign hit         = |(field[BIRD_COL*ROWS +: ROWS] & bird);
    assign score_event = step & tags[BIRD_COL] & ~collision & ~hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collision   <= 1'b0;
            score       <= '0;
            pipe_passed <= 1'b0;
        end else begin
            collision   <= collision | hit;
            pipe_passed <= score_event;
            if (score_event && (score != {SCORE_W{1'b1}}))
                score <= score + 1'b1;
        end
    end

endmodule

// File: tb/tb_barrier_scroller.sv
// Scoreboard-driven bench for barrier_scroller at default parameters (BARRIER_LFSR_EN undefined).
module tb_barrier_scroller;

    localparam int ROWS     = 8;
    localparam int NUM_COLS = 16;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     pause = 1'b0;
    logic                     enable2 = 1'b0;
    logic                     run = 1'b0;
    logic [2:0]               gap_pos = '0;
    logic [ROWS-1:0]          bird = '0;
    logic [NUM_COLS*ROWS-1:0] field;
    logic                     collision;
    logic [7:0]               score;
    logic                     pipe_passed;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q[$];
    logic [127:0] e;

    always #5 clk = ~clk;

    barrier_scroller dut (
        .clk(clk), .reset(reset), .pause(pause), .enable2(enable2), .run(run),
        .gap_pos(gap_pos), .bird(bird), .field(field), .collision(collision),
        .score(score), .pipe_passed(pipe_passed)
    );

    function automatic logic [7:0] col(int c);
        return field[c*ROWS +: ROWS];
    endfunction

    task automatic do_step();
        @(negedge clk) enable2 = 1'b1;
        @(negedge clk) enable2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; pause = 1'b0; enable2 = 1'b0; run = 1'b0; bird = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        run = 1'b1; gap_pos = 3'd2; bird = 8'h40;
        repeat (17) do_step();
        @(negedge clk);
        exp_q.push_back(128'd1);
        e = exp_q.pop_front(); total++;
        if (collision !== e[0]) begin bad++; $display("FAIL reset_pre_collision got=%b exp=%b", collision, e[0]); end
        exp_q.push_back(128'd0); exp_q.push_back(128'd0); exp_q.push_back(128'd0);
        #2 reset = 1'b0;
        #1;
        e = exp_q.pop_front(); total++;
        if (field !== e) begin bad++; $display("FAIL reset_field got=%h exp=%h", field, e); end
        e = exp_q.pop_front(); total++;
        if (collision !== e[0]) begin bad++; $display("FAIL reset_collision got=%b exp=%b", collision, e[0]); end
        e = exp_q.pop_front(); total++;
        if (score !== e[7:0]) begin bad++; $display("FAIL reset_score got=%0d exp=%0d", score, e[7:0]); end
        @(negedge clk) reset = 1'b1; bird = '0;
        for (int s = 1; s <= 5; s++) begin
            exp_q.push_back((s == 5) ? 128'hE3 : 128'h0);
            do_step();
            e = exp_q.pop_front(); total++;
            if (col(15) !== e[7:0]) begin bad++; $display("FAIL reset_restart step=%0d got=%h exp=%h", s, col(15), e[7:0]); end
        end
    endtask

    task automatic test_pipe();
        logic [7:0] c15 [1:7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE3, 8'hE3, 8'h00};
        logic [7:0] c14 [1:7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE3, 8'hE3};
        do_reset();
        run = 1'b1; gap_pos = 3'd2;
        for (int s = 1; s <= 7; s++) begin
            exp_q.push_back({112'd0, c14[s], c15[s]});
            do_step();
            e = exp_q.pop_front(); total++;
            if ({col(14), col(15)} !== {e[15:8], e[7:0]}) begin
                bad++; $display("FAIL pipe step=%0d got c14=%h c15=%h exp c14=%h c15=%h", s, col(14), col(15), e[15:8], e[7:0]);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        run = 1'b1; gap_pos = 3'd2;
        repeat (5) do_step();
        pause = 1'b1;
        repeat (10) do_step();
        exp_q.push_back({112'd0, 8'h00, 8'hE3});
        e = exp_q.pop_front(); total++;
        if ({col(14), col(15)} !== e[15:0]) begin bad++; $display("FAIL pause_hold got=%h%h exp=%h", col(14), col(15), e[15:0]); end
        exp_q.push_back(128'd0);
        e = exp_q.pop_front(); total++;
        if (score !== e[7:0]) begin bad++; $display("FAIL pause_score got=%0d exp=%0d", score, e[7:0]); end
        pause = 1'b0;
        exp_q.push_back({112'd0, 8'hE3, 8'hE3});
        exp_q.push_back({112'd0, 8'hE3, 8'h00});
        do_step();
        e = exp_q.pop_front(); total++;
        if ({col(14), col(15)} !== e[15:0]) begin bad++; $display("FAIL pause_resume1 got=%h%h exp=%h", col(14), col(15), e[15:0]); end
        do_step();
        e = exp_q.pop_front(); total++;
        if ({col(14), col(15)} !== e[15:0]) begin bad++; $display("FAIL pause_resume2 got=%h%h exp=%h", col(14), col(15), e[15:0]); end
    endtask

    task automatic test_clamp();
        do_reset();
        run = 1'b1; gap_pos = 3'd7;
        exp_q.push_back(128'h1F);
        repeat (5) do_step();
        e = exp_q.pop_front(); total++;
        if (col(15) !== e[7:0]) begin bad++; $display("FAIL clamp got=%h exp=%h", col(15), e[7:0]); end
    endtask

    task automatic test_score();
        do_reset();
        run = 1'b1; gap_pos = 3'd2; bird = 8'h08;
        repeat (18) do_step();
        exp_q.push_back(128'd0);
        e = exp_q.pop_front(); total++;
        if ({score, pipe_passed} !== {e[7:0], 1'b0}) begin bad++; $display("FAIL score_before got=%0d/%b exp=%0d/0", score, pipe_passed, e[7:0]); end
        exp_q.push_back({119'd0, 1'b1, 8'd1});
        do_step();
        e = exp_q.pop_front(); total++;
        if ({pipe_passed, score} !== e[8:0]) begin bad++; $display("FAIL score_event got=%b/%0d exp=%b/%0d", pipe_passed, score, e[8], e[7:0]); end
        exp_q.push_back({119'd0, 1'b0, 8'd1});
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if ({pipe_passed, score} !== e[8:0]) begin bad++; $display("FAIL score_pulse_end got=%b/%0d exp=%b/%0d", pipe_passed, score, e[8], e[7:0]); end
        exp_q.push_back(128'd0);
        e = exp_q.pop_front(); total++;
        if (collision !== e[0]) begin bad++; $display("FAIL score_no_collision got=%b exp=%b", collision, e[0]); end
    endtask

    task automatic test_collision();
        do_reset();
        run = 1'b1; gap_pos = 3'd2; bird = 8'h40;
        repeat (16) do_step();
        @(negedge clk) enable2 = 1'b1;
        @(negedge clk) enable2 = 1'b0;
        exp_q.push_back(128'd0);
        e = exp_q.pop_front(); total++;
        if (collision !== e[0]) begin bad++; $display("FAIL collision_latency got=%b exp=%b", collision, e[0]); end
        exp_q.push_back(128'd1);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (collision !== e[0]) begin bad++; $display("FAIL collision_set got=%b exp=%b", collision, e[0]); end
        bird = 8'h00;
        exp_q.push_back({119'd0, 1'b1, 1'b0, 8'd0});
        repeat (2) do_step();
        e = exp_q.pop_front(); total++;
        if ({collision, pipe_passed, score} !== e[9:0]) begin
            bad++; $display("FAIL collision_no_score got=%b/%b/%0d exp=%b/%b/%0d", collision, pipe_passed, score, e[9], e[8], e[7:0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        run = 1'b1; gap_pos = 3'd2; bird = 8'h08;
        // Pipe n passes on step 19+6*(n-1); step 1555 is the 257th pass.
        repeat (1555) do_step();
        exp_q.push_back({119'd0, 1'b1, 8'd255});
        e = exp_q.pop_front(); total++;
        if ({pipe_passed, score} !== e[8:0]) begin bad++; $display("FAIL saturation got=%b/%0d exp=%b/%0d", pipe_passed, score, e[8], e[7:0]); end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_pause();
        test_clamp();
        test_score();
        test_collision();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/barrier_scroller.md
Name: barrier_scroller

Overview:
- Parametrised successor to the single playfield column register. Holds the entire scrolling barrier field of NUM_COLS columns × ROWS rows.
- Generates pipe columns internally: spacing/pipe FSM with a configurable gap.
- Checks the bird's row against a fixed bird column for collision, and counts pipes passed as the score.
- Sits between the game timing block (scroll tick, pause) and the LED matrix driver / score display.

Parameters:
- ROWS, 8, rows per column (LED height)
- NUM_COLS, 16, columns in the field
- SPACING, 4, empty columns injected between pipes (≥1)
- PIPE_WIDTH, 2, columns per pipe (≥1)
- GAP_SIZE, 3, open rows in a pipe (1..ROWS-1)
- BIRD_COL, 3, column index occupied by the bird (1..NUM_COLS-2)
- SCORE_W, 8, score counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pause  in  1  freezes scrolling and spawning; dominates enable2
- enable2  in  1  scroll tick, one-cycle pulse; a step occurs when enable2 & ~pause
- run  in  1  spawning enable; 0 injects empty columns
- gap_pos  in  $clog2(ROWS)  lowest open row of the next pipe
- bird  in  ROWS  one-hot bird row vector at BIRD_COL
- field  out  NUM_COLS*ROWS  column c = field[c*ROWS +: ROWS]; bit r = row r; 1 = barrier lit
- collision  out  1  sticky collision flag
- score  out  SCORE_W  pipes passed, saturating
- pipe_passed  out  1  one-cycle pulse on each score event

Behaviour:
- **Reset** (reset=0, asynchronous):
  - field=0, tag bits=0, collision=0, score=0, pipe_passed=0.
  - FSM in S_SPACE with cnt=0; latched gap=0.
- **Step** = enable2 & ~pause, sampled on the posedge.
  - On a step: column c ← column c+1 for c < NUM_COLS-1, and column NUM_COLS-1 ← new_col.
  - Each column carries a 1-bit tag, shifted identically.
  - No step: everything holds.
- **Spawner FSM** (transitions only on a step):
  - S_SPACE: new_col=0. If cnt==SPACING-1: go to S_PIPE, cnt←0, gap←clamp(gap_pos). Else cnt++.
  - S_PIPE: new_col = all ones except rows gap..gap+GAP_SIZE-1. If cnt==PIPE_WIDTH-1: inject with tag=1, go to S_SPACE, cnt←0. Else cnt++, tag=0.
  - clamp(x) = min(x, ROWS-GAP_SIZE).
  - run=0 on a step: inject 0 with tag 0, force S_SPACE with cnt=0.
  - run=1 after reset: steps 1..SPACING inject zeros; step SPACING+1 injects the first pipe column.
- **Collision**:
  - Registered, evaluated every cycle regardless of pause.
  - collision ← collision | (|(column BIRD_COL & bird)); 1-cycle latency.
  - Sticky until reset.
  - bird=0 never collides.
- **Score**:
  - Event when a step moves a tagged column from BIRD_COL to BIRD_COL-1 and collision=0 (pre-step value).
  - On an event, score++ saturating at 2^SCORE_W-1, and pipe_passed=1 for exactly the following cycle.
  - pipe_passed is registered and still pulses at saturation.
- **Edge cases**:
  - Simultaneous collision detect and score step: no score.
  - Pause held: collision may still set, no score.
  - Reset mid-pipe: FSM restarts at S_SPACE; partial pipe is discarded.

Optional Feature:
- Macro: BARRIER_LFSR_EN.
- Defined:
  - Internal 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
  - Advances on every step.
  - Gap latched on S_SPACE→S_PIPE = lfsr % (ROWS-GAP_SIZE+1); gap_pos is ignored.
- Undefined: no LFSR; gap comes from clamp(gap_pos).

Test Plan (defaults, BARRIER_LFSR_EN undefined):
1. Reset low mid-run with field nonzero and collision=1 → immediately field=0, collision=0, score=0; after release, first pipe appears on step 5.
2. run=1, gap_pos=2, 7 steps:
   - After step 5: column 15 = 8'b1110_0011.
   - After step 6: columns 15 and 14 = 8'b1110_0011.
   - After step 7: column 15 = 0.
3. pause=1 with enable2 pulsing 10 times → field, FSM and score unchanged; pause=0 resumes exactly where it left off.
4. gap_pos=7 → clamped to 5; pipe column = 8'b0001_1111.
5. gap_pos=2, bird=8'b0000_1000 (row 3) →
   - After step 19 (trailing column leaves column 3): score=1, single-cycle pipe_passed.
   - collision stays 0.
6. gap_pos=2, bird=8'b0100_0000 (row 6) →
   - Leading pipe column reaches column 3 after step 17; collision=1 one cycle later and stays 1.
   - Step 19 gives no score (score=0, no pulse).
